// File: rtl/controller_rd_if.sv
// Read-side FIFO controller bus: read request/status plus the Gray pointers crossing domains.
// almost_empty is present only when CONTROLLER_RD_ALMOST_EMPTY_EN is defined.
interface controller_rd_if #(
  parameter int unsigned PTRWIDTH = 4
);
  logic                pop;
  logic [PTRWIDTH:0]   wrptr_gray;
  logic                empty;
  logic [PTRWIDTH:0]   rdptr_bin;
  logic [PTRWIDTH:0]   rdptr_gray;
  logic                rd_valid;
  logic [PTRWIDTH:0]   rd_level;
  logic                underflow;
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
  logic                almost_empty;

  modport master (
    output pop, wrptr_gray,
    input  empty, rdptr_bin, rdptr_gray, rd_valid, rd_level, underflow, almost_empty
  );
  modport slave (
    input  pop, wrptr_gray,
    output empty, rdptr_bin, rdptr_gray, rd_valid, rd_level, underflow, almost_empty
  );
`else
  modport master (
    output pop, wrptr_gray,
    input  empty, rdptr_bin, rdptr_gray, rd_valid, rd_level, underflow
  );
  modport slave (
    input  pop, wrptr_gray,
    output empty, rdptr_bin, rdptr_gray, rd_valid, rd_level, underflow
  );
`endif
endinterface

// File: rtl/controller_rd.sv
// Async FIFO read-side controller: binary/Gray read pointer, 2-flop write-pointer sync,
// empty/level/underflow status. Optional almost_empty via CONTROLLER_RD_ALMOST_EMPTY_EN.
module controller_rd #(
  parameter int unsigned PTRWIDTH  = 4,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic            rclk,
  input  logic            reset,
  controller_rd_if.slave  bus
);
  localparam int unsigned W = PTRWIDTH + 1;

  logic [W-1:0] r_wq1;
  logic [W-1:0] r_wq2;
  logic [W-1:0] r_rdptr_bin;
  logic [W-1:0] r_rdptr_gray;
  logic         r_rd_valid;
  logic         r_underflow;

  logic [W-1:0] w_wrptr_sync_bin;
  logic [W-1:0] w_rdptr_bin_next;
  logic [W-1:0] w_rd_level;
  logic         w_empty;
  logic         w_pop_ok;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wrptr_sync_bin        = '0;
    w_wrptr_sync_bin[W-1]   = r_wq2[W-1];
    for (int unsigned i = 0; i < W - 1; i++) begin
      w_wrptr_sync_bin[W-2-i] = w_wrptr_sync_bin[W-1-i] ^ r_wq2[W-2-i];
    end
  end

  assign w_rdptr_bin_next = r_rdptr_bin + 1'b1;
  assign w_empty          = (r_rdptr_bin == w_wrptr_sync_bin);
  assign w_rd_level       = w_wrptr_sync_bin - r_rdptr_bin;
  assign w_pop_ok         = bus.pop & ~w_empty;

  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_wq1 <= '0;
      r_wq2 <= '0;
    end else begin
      r_wq1 <= bus.wrptr_gray;
      r_wq2 <= r_wq1;
    end
  end

  // Gray pointer is loaded from the next binary value so it leaves a register glitch-free.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      r_rdptr_bin  <= '0;
      r_rdptr_gray <= '0;
      r_rd_valid   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      r_rd_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_rdptr_bin  <= w_rdptr_bin_next;
        r_rdptr_gray <= w_rdptr_bin_next ^ (w_rdptr_bin_next >> 1);
      end
      if (bus.pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign bus.empty      = w_empty;
  assign bus.rdptr_bin  = r_rdptr_bin;
  assign bus.rdptr_gray = r_rdptr_gray;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.rd_level   = w_rd_level;
  assign bus.underflow  = r_underflow;

`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
  assign bus.almost_empty = (w_rd_level <= W'(AE_THRESH));
`endif

endmodule

// File: tb/tb_controller_rd.sv
// Self-checking bench for controller_rd: reference model of pointers/sync plus a
// scoreboard of accepted read addresses retired on rd_valid.
module tb_controller_rd;
  localparam int unsigned PW = 4;
  localparam int unsigned AE = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  controller_rd_if #(.PTRWIDTH(PW)) bus ();

  controller_rd #(.PTRWIDTH(PW), .AE_THRESH(AE)) dut (
    .rclk  (clk),
    .reset (rst),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [4:0] m_rp, m_s1, m_s2, m_wp;
  logic       m_uf, m_valid;
  logic [4:0] sb[$];

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    b[4] = g[4];
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [4:0] sync_b, lvl;
    sync_b = g2b(m_s2);
    lvl    = sync_b - m_rp;
    check("rdptr_bin",  bus.rdptr_bin,  m_rp);
    check("rdptr_gray", bus.rdptr_gray, b2g(m_rp));
    check("empty",      bus.empty,      m_rp == sync_b);
    check("rd_level",   bus.rd_level,   lvl);
    check("underflow",  bus.underflow,  m_uf);
    check("rd_valid",   bus.rd_valid,   m_valid);
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
    check("almost_empty", bus.almost_empty, lvl <= 5'(AE));
`endif
  endtask

  // Called at a negedge: drive inputs, advance the model over the next posedge, compare.
  task automatic step(input logic p, input logic [4:0] wbin);
    logic       acc;
    logic [4:0] prev_gray, addr;
    bus.pop        = p;
    bus.wrptr_gray = b2g(wbin);
    m_wp           = wbin;
    acc = p && (m_rp != g2b(m_s2));
    if (acc) begin
      sb.push_back(m_rp);
      m_rp = m_rp + 5'd1;
    end
    if (p && !acc) m_uf = 1'b1;
    m_valid   = acc;
    m_s2      = m_s1;
    m_s1      = b2g(wbin);
    prev_gray = bus.rdptr_gray;
    @(posedge clk);
    #1;
    compare_all();
    check("gray_one_bit", $countones(prev_gray ^ bus.rdptr_gray) <= 1, 1);
    if (bus.rd_valid) begin
      if (sb.size() == 0) check("sb_extra_valid", 1, 0);
      else begin
        addr = bus.rdptr_bin - 5'd1;
        check("rd_addr", addr, sb.pop_front());
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_rp = '0; m_s1 = '0; m_s2 = '0; m_uf = 1'b0; m_valid = 1'b0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.pop = 1'b0;
    bus.wrptr_gray = '0;
    m_wp = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b0;
    @(negedge clk);

    // Advance read pointer to 7, then reset asynchronously mid-cycle.
    step(1'b0, 5'd10);
    step(1'b0, 5'd10);
    for (int i = 0; i < 7; i++) step(1'b1, 5'd10);
    check("pre_reset_rp", bus.rdptr_bin, 5'd7);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_rdptr_bin",  bus.rdptr_bin,  5'd0);
    check("rst_rdptr_gray", bus.rdptr_gray, 5'd0);
    check("rst_empty",      bus.empty,      1'b1);
    check("rst_level",      bus.rd_level,   5'd0);
    check("rst_underflow",  bus.underflow,  1'b0);
    check("rst_valid",      bus.rd_valid,   1'b0);
`ifdef CONTROLLER_RD_ALMOST_EMPTY_EN
    check("rst_almost_empty", bus.almost_empty, 1'b1);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Write pointer 3 takes two edges to appear.
    step(1'b0, 5'd3);
    check("sync_lat_empty", bus.empty, 1'b1);
    step(1'b0, 5'd3);
    check("sync_empty", bus.empty, 1'b0);
    check("sync_level", bus.rd_level, 5'd3);

    // Drain three, fourth pop underflows.
    for (int i = 0; i < 4; i++) step(1'b1, 5'd3);
    check("uf_set",   bus.underflow, 1'b1);
    check("uf_rp",    bus.rdptr_bin, 5'd3);
    step(1'b0, 5'd3);
    check("uf_sticky", bus.underflow, 1'b1);

    // Full level: sync=19, rp=3.
    step(1'b0, 5'd19);
    step(1'b0, 5'd19);
    check("full_level", bus.rd_level, 5'd16);
    check("full_empty", bus.empty,    1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 5'd19);
    check("full_drained", bus.empty, 1'b1);

    // Wrap: write pointer at 33 mod 32.
    step(1'b0, 5'd1);
    step(1'b0, 5'd1);
    for (int i = 0; i < 12; i++) step(1'b1, 5'd1);
    check("pre_wrap_rp",   bus.rdptr_bin,  5'd31);
    check("pre_wrap_gray", bus.rdptr_gray, 5'b10000);
    step(1'b1, 5'd1);
    check("wrap_rp",   bus.rdptr_bin,  5'd0);
    check("wrap_gray", bus.rdptr_gray, 5'b00000);
    step(1'b1, 5'd1);
    check("post_wrap_rp",    bus.rdptr_bin, 5'd1);
    check("post_wrap_empty", bus.empty,     1'b1);

    // Random traffic; writer never exceeds depth.
    for (int i = 0; i < 300; i++) begin
      logic [4:0] w, d;
      w = m_wp;
      d = m_wp - m_rp;
      if ($urandom_range(0, 2) != 0 && d < 5'd16) w = m_wp + 5'd1;
      step(1'($urandom_range(0, 1)), w);
    end
    for (int i = 0; i < 3; i++) step(1'b0, m_wp);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
